// File: rtl/seven_seg_scan_if.sv
// User-side bundle for the 7-segment scan controller: value/load in, shared seg/an pins out.
interface seven_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output en, load, value, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, load, value, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display,
// with frame-atomic value updates, anti-ghost blanking and leading-zero suppression.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_scan_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]      stage_q, stage_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  xfer;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            nib;
  logic                  cur_lz;
  logic                  cur_dp;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!bus.en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // frame_done_q is high exactly in the last SHOW cycle of the last digit,
  // so it doubles as the frame-boundary marker for the shadow transfer.
  always_comb begin
    xfer        = (state_q == ST_IDLE) || frame_done_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;
    stage_d     = bus.load ? bus.value : stage_q;
    stage_dp_d  = bus.load ? bus.dp_in : stage_dp_q;
    if (xfer) begin
      pend_d = 1'b0;
      if (bus.load) begin
        shadow_d    = bus.value;
        shadow_dp_d = bus.dp_in;
      end else if (pend_q) begin
        shadow_d    = stage_q;
        shadow_dp_d = stage_dp_q;
      end
    end else if (bus.load) begin
      pend_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with the FSM.
  always_comb begin
    all_zero = 1'b1;
    lz_blank = '0;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      all_zero      = all_zero & (shadow_d[4*(k-1) +: 4] == 4'h0);
      lz_blank[k-1] = bus.blank_lz && (k > 1) && all_zero;
    end

    nib    = '0;
    cur_lz = 1'b0;
    cur_dp = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib    = shadow_d[4*i +: 4];
        cur_lz = lz_blank[i];
        cur_dp = shadow_dp_d[i];
      end
    end

    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if (state_d == ST_SHOW) begin
      if (!cur_lz || cur_dp) an_d[idx_d] = 1'b0;
      if (!cur_lz) seg_d = glyph(nib);
      dp_d = ~cur_dp;
    end
    frame_done_d = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      stage_q      <= '0;
      stage_dp_q   <= '0;
      pend_q       <= 1'b0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      stage_q      <= stage_d;
      stage_dp_q   <= stage_dp_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
